fifo_bank: RTL and testbench

FIFO_BANK -- requirements
Module: fifo_bank

---
 rtl/fifo_bank_pkg.sv | 12 +
 rtl/fifo_bank_if.sv | 37 +++
 rtl/fifo_chan.sv | 90 +++++++++
 rtl/fifo_bank.sv | 64 ++++++
 tb/tb_fifo_bank.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_bank_pkg.sv
// Shared constants and helpers for the fifo_bank channel array.
package fifo_bank_pkg;

    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    // Occupancy must represent 0..depth inclusive, hence depth+1 states.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_bank_if.sv
// Bundled per-channel push/pop bus for fifo_bank; broadcast signals exist only with FIFO_BANK_BCAST_EN.
interface fifo_bank_if
    import fifo_bank_pkg::*;
#(
    parameter int PCKG_SZ = 32,
    parameter int DRVRS   = 4
);

    logic [DRVRS-1:0]                push;
    logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push;
    logic [DRVRS-1:0]                pop;
    logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop;
    logic [DRVRS-1:0]                pndng;
    logic [DRVRS-1:0]                full;
    logic [DRVRS-1:0][DROP_W-1:0]    drop_cnt;
`ifdef FIFO_BANK_BCAST_EN
    logic                            bcast_push;
    logic [PCKG_SZ-1:0]              D_bcast;
`endif

    modport master (
`ifdef FIFO_BANK_BCAST_EN
        output bcast_push, D_bcast,
`endif
        output push, D_push, pop,
        input  D_pop, pndng, full, drop_cnt
    );

    modport slave (
`ifdef FIFO_BANK_BCAST_EN
        input  bcast_push, D_bcast,
`endif
        input  push, D_push, pop,
        output D_pop, pndng, full, drop_cnt
    );

endinterface

// File: rtl/fifo_chan.sv
// One first-word-fall-through channel: circular storage, pointers, occupancy and saturating drop counter.
module fifo_chan
    import fifo_bank_pkg::*;
#(
    parameter int PCKG_SZ = 32,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [PCKG_SZ-1:0] data_i,
    input  logic               pop_i,
    input  logic               collide_i,
    output logic [PCKG_SZ-1:0] data_o,
    output logic               pndng_o,
    output logic               full_o,
    output logic [DROP_W-1:0]  dropCnt_o
);

    localparam int CNT_W = cntWidth(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PCKG_SZ-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrNext, rdNext;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PCKG_SZ-1:0] head_q, head_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               doPop, doPush;
    logic [1:0]         dropInc;
    logic [DROP_W:0]    dropSum;

    // A full channel still accepts a push when the head leaves in the same cycle.
    always_comb begin
        doPop   = pop_i && (count_q != '0);
        doPush  = push_i && ((count_q != CNT_FULL) || doPop);
        wrNext  = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + 1'b1;
        rdNext  = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + 1'b1;
        wrPtr_d = doPush ? wrNext : wrPtr_q;
        rdPtr_d = doPop ? rdNext : rdPtr_q;
        count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);

        dropInc = 2'(push_i && !doPush) + 2'(collide_i);
        dropSum = {1'b0, drop_q} + (DROP_W+1)'(dropInc);
        drop_d  = (dropSum > {1'b0, DROP_MAX}) ? DROP_MAX : dropSum[DROP_W-1:0];

        // Head register holds its last value once the channel drains.
        head_d = head_q;
        if (doPop) begin
            if (count_q > CNT_ONE) begin
                head_d = mem_q[rdNext];
            end else if (doPush) begin
                head_d = data_i;
            end
        end else if (doPush && (count_q == '0)) begin
            head_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !reset) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
            drop_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            head_q  <= head_d;
            drop_q  <= drop_d;
        end
    end

    assign data_o    = head_q;
    assign pndng_o   = (count_q != '0);
    assign full_o    = (count_q == CNT_FULL);
    assign dropCnt_o = drop_q;

endmodule

// File: rtl/fifo_bank.sv
// Array of DRVRS independent FWFT channels; define FIFO_BANK_BCAST_EN to add a broadcast write to all channels.
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int PCKG_SZ = 32,
    parameter int DRVRS   = 4,
    parameter int DEPTH   = 8
) (
    input  logic      clk,
    input  logic      reset,
    fifo_bank_if.slave bus
);

    logic               chPush    [DRVRS];
    logic               chCollide [DRVRS];
    logic [PCKG_SZ-1:0] chData    [DRVRS];
    logic [PCKG_SZ-1:0] chDPop    [DRVRS];
    logic               chPndng   [DRVRS];
    logic               chFull    [DRVRS];
    logic [DROP_W-1:0]  chDrop    [DRVRS];

    // Broadcast wins the write port; a coinciding local push is counted as a drop.
    always_comb begin
        for (int i = 0; i < DRVRS; i++) begin
`ifdef FIFO_BANK_BCAST_EN
            chPush[i]    = bus.bcast_push | bus.push[i];
            chData[i]    = bus.bcast_push ? bus.D_bcast : bus.D_push[i];
            chCollide[i] = bus.bcast_push & bus.push[i];
`else
            chPush[i]    = bus.push[i];
            chData[i]    = bus.D_push[i];
            chCollide[i] = 1'b0;
`endif
        end
    end

    for (genvar g = 0; g < DRVRS; g++) begin : gChan
        fifo_chan #(
            .PCKG_SZ (PCKG_SZ),
            .DEPTH   (DEPTH)
        ) uChan (
            .clk       (clk),
            .reset     (reset),
            .push_i    (chPush[g]),
            .data_i    (chData[g]),
            .pop_i     (bus.pop[g]),
            .collide_i (chCollide[g]),
            .data_o    (chDPop[g]),
            .pndng_o   (chPndng[g]),
            .full_o    (chFull[g]),
            .dropCnt_o (chDrop[g])
        );
    end

    always_comb begin
        for (int i = 0; i < DRVRS; i++) begin
            bus.D_pop[i]    = chDPop[i];
            bus.pndng[i]    = chPndng[i];
            bus.full[i]     = chFull[i];
            bus.drop_cnt[i] = chDrop[i];
        end
    end

endmodule

// File: tb/tb_fifo_bank.sv
// Scoreboard bench for fifo_bank: a DEPTH=8 four-channel bank and a DEPTH=5 two-channel bank side by side.
module tb_fifo_bank;
    import fifo_bank_pkg::*;

    localparam int NCH = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_bank_if #(.PCKG_SZ(32), .DRVRS(4)) if8 ();
    fifo_bank_if #(.PCKG_SZ(32), .DRVRS(2)) if5 ();

    fifo_bank #(.PCKG_SZ(32), .DRVRS(4), .DEPTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));
    fifo_bank #(.PCKG_SZ(32), .DRVRS(2), .DEPTH(5)) dut5 (.clk(clk), .reset(reset), .bus(if5));

    int nCmp  = 0;
    int nFail = 0;

    logic [31:0] mq    [NCH][$];
    int          mDrop [NCH];
    logic [31:0] mHead [NCH];

    logic           sReset;
    logic [NCH-1:0] sPush, sPop;
    logic [31:0]    sData [NCH];
    logic           sBcast;
    logic [31:0]    sBData;

    function automatic int depthOf(input int ch);
        return (ch < 4) ? 8 : 5;
    endfunction

    task automatic compare(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s ch%0d observed=%h expected=%h", tag, ch, obs, exp);
        end
    endtask

    task automatic clearStim();
        sReset = 1'b0;
        sPush  = '0;
        sPop   = '0;
        sBcast = 1'b0;
        sBData = '0;
        for (int i = 0; i < NCH; i++) sData[i] = '0;
    endtask

    task automatic driveInputs();
        reset = sReset;
        for (int i = 0; i < 4; i++) begin
            if8.push[i]   = sPush[i];
            if8.pop[i]    = sPop[i];
            if8.D_push[i] = sData[i];
        end
        for (int i = 0; i < 2; i++) begin
            if5.push[i]   = sPush[i+4];
            if5.pop[i]    = sPop[i+4];
            if5.D_push[i] = sData[i+4];
        end
`ifdef FIFO_BANK_BCAST_EN
        if8.bcast_push = sBcast;
        if8.D_bcast    = sBData;
        if5.bcast_push = sBcast;
        if5.D_bcast    = sBData;
`endif
    endtask

    task automatic modelEdge();
        for (int ch = 0; ch < NCH; ch++) begin
            if (sReset) begin
                mq[ch].delete();
                mDrop[ch] = 0;
                mHead[ch] = '0;
            end else begin
                logic        effPush, doPop, accept;
                logic [31:0] effData;
                int          collide;
                effPush = sPush[ch];
                effData = sData[ch];
                collide = 0;
`ifdef FIFO_BANK_BCAST_EN
                if (sBcast) begin
                    collide = sPush[ch] ? 1 : 0;
                    effPush = 1'b1;
                    effData = sBData;
                end
`endif
                doPop  = sPop[ch] && (mq[ch].size() > 0);
                accept = effPush && ((mq[ch].size() < depthOf(ch)) || doPop);
                if (doPop) void'(mq[ch].pop_front());
                if (accept) mq[ch].push_back(effData);
                mDrop[ch] = mDrop[ch] + ((effPush && !accept) ? 1 : 0) + collide;
                if (mDrop[ch] > 255) mDrop[ch] = 255;
                if (mq[ch].size() > 0) mHead[ch] = mq[ch][0];
            end
        end
    endtask

    task automatic checkOutput();
        for (int ch = 0; ch < NCH; ch++) begin
            logic [31:0] dp, expDp;
            logic        pn, fl;
            logic [7:0]  dc;
            if (ch < 4) begin
                dp = if8.D_pop[ch];
                pn = if8.pndng[ch];
                fl = if8.full[ch];
                dc = if8.drop_cnt[ch];
            end else begin
                dp = if5.D_pop[ch-4];
                pn = if5.pndng[ch-4];
                fl = if5.full[ch-4];
                dc = if5.drop_cnt[ch-4];
            end
            expDp = (mq[ch].size() > 0) ? mq[ch][0] : mHead[ch];
            compare("pndng", ch, 32'(pn), 32'(mq[ch].size() > 0));
            compare("full", ch, 32'(fl), 32'(mq[ch].size() == depthOf(ch)));
            compare("D_pop", ch, dp, expDp);
            compare("drop_cnt", ch, 32'(dc), 32'(mDrop[ch]));
        end
    endtask

    task automatic applyStimulus();
        driveInputs();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        clearStim();
        sReset = 1'b1;
        driveInputs();
        @(negedge clk);

        // Reset must beat a simultaneous push on every channel.
        sPush = '1;
        for (int i = 0; i < NCH; i++) sData[i] = 32'hDEAD_0000 + 32'(i);
        applyStimulus();
        applyStimulus();
        clearStim();
        applyStimulus();

        $display("[TB] single push on channel 0");
        sPush[0] = 1'b1;
        sData[0] = 32'hA5A5_0001;
        applyStimulus();
        clearStim();
        compare("req031_dpop", 0, if8.D_pop[0], 32'hA5A5_0001);
        compare("req031_pndng1", 1, 32'(if8.pndng[1]), 32'd0);
        sPop[0] = 1'b1;
        applyStimulus();
        clearStim();

        $display("[TB] fill channel 2 and overflow");
        for (int k = 1; k <= 9; k++) begin
            sPush[2] = 1'b1;
            sData[2] = 32'h2000_0000 + 32'(k);
            applyStimulus();
        end
        clearStim();
        compare("req032_drop", 2, 32'(if8.drop_cnt[2]), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            compare("req032_order", 2, if8.D_pop[2], 32'h2000_0000 + 32'(k));
            sPop[2] = 1'b1;
            applyStimulus();
        end
        clearStim();

        $display("[TB] push and pop together on a full channel");
        for (int k = 1; k <= 8; k++) begin
            sPush[2] = 1'b1;
            sData[2] = 32'h3000_0000 + 32'(k);
            applyStimulus();
        end
        sPop[2]  = 1'b1;
        sData[2] = 32'h3000_00AA;
        applyStimulus();
        clearStim();
        compare("req033_full", 2, 32'(if8.full[2]), 32'd1);
        for (int k = 0; k < 8; k++) begin
            sPop[2] = 1'b1;
            applyStimulus();
        end
        clearStim();

        $display("[TB] pop on empty channel 1 and drop saturation on channel 3");
        sPush[1] = 1'b1;
        sData[1] = 32'h1111_2222;
        applyStimulus();
        clearStim();
        sPop[1] = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus();
        clearStim();
        compare("req034_hold", 1, if8.D_pop[1], 32'h1111_2222);
        for (int k = 0; k < 300; k++) begin
            sPush[3] = 1'b1;
            sData[3] = 32'h4000_0000 + 32'(k);
            applyStimulus();
        end
        clearStim();
        compare("req034_sat", 3, 32'(if8.drop_cnt[3]), 32'd255);

        $display("[TB] random traffic on both banks");
        for (int k = 0; k < 200; k++) begin
            sPush = NCH'($urandom);
            sPop  = NCH'($urandom);
            for (int i = 0; i < NCH; i++) sData[i] = $urandom;
            applyStimulus();
        end
        clearStim();

        $display("[TB] DEPTH=5 wrap and mid-stream reset");
        sReset = 1'b1;
        applyStimulus();
        clearStim();
        for (int k = 0; k < 3; k++) begin
            sPush[4] = 1'b1;
            sData[4] = 32'h5000_0000 + 32'(k);
            applyStimulus();
        end
        for (int k = 0; k < 12; k++) begin
            clearStim();
            sPush[4] = 1'b1;
            sData[4] = 32'h5100_0000 + 32'(k);
            applyStimulus();
            clearStim();
            sPop[4] = 1'b1;
            applyStimulus();
        end
        clearStim();
        sReset   = 1'b1;
        sPush[4] = 1'b1;
        sData[4] = 32'h5200_0000;
        applyStimulus();
        clearStim();
        compare("req035_rst_pndng", 4, 32'(if5.pndng[0]), 32'd0);
        compare("req035_rst_dpop", 4, if5.D_pop[0], 32'd0);
        sPush[4] = 1'b1;
        sData[4] = 32'h5300_0001;
        applyStimulus();
        clearStim();
        compare("req025_first", 4, if5.D_pop[0], 32'h5300_0001);

`ifdef FIFO_BANK_BCAST_EN
        $display("[TB] broadcast with channel 3 full");
        sReset = 1'b1;
        applyStimulus();
        clearStim();
        for (int k = 1; k <= 8; k++) begin
            sPush[3] = 1'b1;
            sData[3] = 32'h6000_0000 + 32'(k);
            applyStimulus();
        end
        clearStim();
        sBcast   = 1'b1;
        sBData   = 32'hFFFF_0000;
        sPush[0] = 1'b1;
        sData[0] = 32'h7777_7777;
        applyStimulus();
        clearStim();
        compare("req036_ch2", 2, if8.D_pop[2], 32'hFFFF_0000);
        compare("req036_drop3", 3, 32'(if8.drop_cnt[3]), 32'd1);
        compare("req027_collide", 0, 32'(if8.drop_cnt[0]), 32'd1);
        sPop = '1;
        for (int k = 0; k < 9; k++) applyStimulus();
        clearStim();
`endif

        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
